// File: rtl/cache_evict_fill_pkg.sv
// Shared definitions for the miss-handling evict/fill block: FSM states and
// the geometry helpers that turn the offset/word widths into line, beat and
// physical-address sizes.
package cache_evict_fill_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVICT  = 2'd1,
        FETCH  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Line size in bits for a line of 2^offsetlen bytes.
    function automatic int calc_linelen(input int offsetlen);
        return 8 * (1 << offsetlen);
    endfunction

    // Number of bus beats needed to move one line.
    function automatic int calc_beats(input int offsetlen, input int wordlen);
        return calc_linelen(offsetlen) / wordlen;
    endfunction

    // Physical address width: tag, set index and byte offset.
    function automatic int calc_palen(input int taglen, input int setlen, input int offsetlen);
        return taglen + setlen + offsetlen;
    endfunction

    // Beat counter width; a line is assumed to span at least two beats.
    function automatic int calc_beatw(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cache_evict_fill_if.sv
// Signal bundle between the cache controller / replacement policy / bus and
// the evict-fill block. The block itself connects through the slave modport.
interface cache_evict_fill_if #(
    parameter int NUMWAYS   = 4,
    parameter int SETLEN    = 9,
    parameter int OFFSETLEN = 5,
    parameter int TAGLEN    = 20,
    parameter int WORDLEN   = 64
) ();
    import cache_evict_fill_pkg::*;

    localparam int LINELEN = calc_linelen(OFFSETLEN);
    localparam int PALEN   = calc_palen(TAGLEN, SETLEN, OFFSETLEN);

    // Miss request
    logic                 MissValid;
    logic                 MissReady;
    logic [TAGLEN-1:0]    MissTag;
    logic [SETLEN-1:0]    MissSet;

    // Victim chosen by the replacement policy
    logic [NUMWAYS-1:0]   VictimWay;
    logic                 VictimDirty;
    logic [TAGLEN-1:0]    VictimTag;
    logic [LINELEN-1:0]   VictimLine;

    // Memory bus
    logic                 BusReq;
    logic                 BusWrite;
    logic [PALEN-1:0]     BusAdr;
    logic [WORDLEN-1:0]   BusWData;
    logic [WORDLEN-1:0]   BusRData;
    logic                 BusReady;

    // Cache array side
    logic [NUMWAYS-1:0]   FillWay;
    logic [SETLEN-1:0]    FillSet;
    logic [LINELEN-1:0]   FillLine;
    logic                 FillWriteEn;
    logic                 ClearValid;
    logic                 SetValid;
    logic                 LRUWriteEn;
    logic                 Done;

    modport slave (
        input  MissValid, MissTag, MissSet,
        input  VictimWay, VictimDirty, VictimTag, VictimLine,
        input  BusRData, BusReady,
        output MissReady,
        output BusReq, BusWrite, BusAdr, BusWData,
        output FillWay, FillSet, FillLine, FillWriteEn,
        output ClearValid, SetValid, LRUWriteEn, Done
    );

    modport master (
        output MissValid, MissTag, MissSet,
        output VictimWay, VictimDirty, VictimTag, VictimLine,
        output BusRData, BusReady,
        input  MissReady,
        input  BusReq, BusWrite, BusAdr, BusWData,
        input  FillWay, FillSet, FillLine, FillWriteEn,
        input  ClearValid, SetValid, LRUWriteEn, Done
    );

endinterface

// File: rtl/cache_evict_fill_beatcounter.sv
// Beat counter for line transfers: cleared when a miss is accepted, advanced
// on each completed bus beat, wrapping to zero after the last beat.
module cache_evict_fill_beatcounter #(
    parameter int BEATS = 4,
    parameter int BEATW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [BEATW-1:0] beat,
    output logic             last
);

    assign last = (beat == BEATW'(BEATS - 1));

    // Clear has priority so a new miss always starts at beat 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (en) begin
            beat <= last ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: rtl/cache_evict_fill.sv
// Miss handler: on an accepted miss it writes back a dirty victim line beat
// by beat, fetches the missing line into a line buffer, then commits the line
// to the cache array in a single cycle.
module cache_evict_fill
    import cache_evict_fill_pkg::*;
#(
    parameter int NUMWAYS   = 4,
    parameter int SETLEN    = 9,
    parameter int OFFSETLEN = 5,
    parameter int TAGLEN    = 20,
    parameter int WORDLEN   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_evict_fill_if.slave    bus
);

    localparam int LINELEN = calc_linelen(OFFSETLEN);
    localparam int BEATS   = calc_beats(OFFSETLEN, WORDLEN);
    localparam int BEATW   = calc_beatw(BEATS);
    // Byte-within-beat address bits, always zero on the bus.
    localparam int ZEROW   = OFFSETLEN - BEATW;

    state_t               state;
    state_t               state_nx;

    logic [TAGLEN-1:0]    tag_q;
    logic [TAGLEN-1:0]    vtag_q;
    logic [SETLEN-1:0]    set_q;
    logic [NUMWAYS-1:0]   way_q;
    logic [LINELEN-1:0]   line_q;
    logic                 first_q;

    logic                 accept;
    logic                 beat_en;
    logic                 beat_last;
    logic [BEATW-1:0]     beat;

    assign accept  = bus.MissValid && (state == IDLE);
    // BusReq is only raised in EVICT/FETCH, so a stray BusReady elsewhere
    // never advances the counter or stores data.
    assign beat_en = bus.BusReq && bus.BusReady;

    cache_evict_fill_beatcounter #(
        .BEATS (BEATS),
        .BEATW (BEATW)
    ) u_beatcounter (
        .clk   (clk),
        .reset (reset),
        .en    (beat_en),
        .clr   (accept),
        .beat  (beat),
        .last  (beat_last)
    );

    // Cache-side outputs come straight from the latched miss; the line buffer
    // holds the victim during EVICT and is overwritten by fetched beats.
    assign bus.FillWay    = way_q;
    assign bus.FillSet    = set_q;
    assign bus.FillLine   = line_q;
    assign bus.ClearValid = first_q;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and bus/commit outputs.
    always_comb begin
        state_nx        = state;
        bus.MissReady   = 1'b0;
        bus.BusReq      = 1'b0;
        bus.BusWrite    = 1'b0;
        bus.BusAdr      = '0;
        bus.BusWData    = '0;
        bus.FillWriteEn = 1'b0;
        bus.SetValid    = 1'b0;
        bus.LRUWriteEn  = 1'b0;
        bus.Done        = 1'b0;
        case (state)
            IDLE: begin
                bus.MissReady = 1'b1;
                if (bus.MissValid) begin
                    state_nx = bus.VictimDirty ? EVICT : FETCH;
                end
            end
            EVICT: begin
                bus.BusReq   = 1'b1;
                bus.BusWrite = 1'b1;
                bus.BusAdr   = {vtag_q, set_q, beat, {ZEROW{1'b0}}};
                bus.BusWData = line_q[int'(beat)*WORDLEN +: WORDLEN];
                if (beat_en && beat_last) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                bus.BusReq = 1'b1;
                bus.BusAdr = {tag_q, set_q, beat, {ZEROW{1'b0}}};
                if (beat_en && beat_last) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                bus.FillWriteEn = 1'b1;
                bus.SetValid    = 1'b1;
                bus.LRUWriteEn  = 1'b1;
                bus.Done        = 1'b1;
                state_nx        = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the miss and victim on accept; collect fetched beats afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q   <= '0;
            vtag_q  <= '0;
            set_q   <= '0;
            way_q   <= '0;
            line_q  <= '0;
            first_q <= 1'b0;
        end else begin
            first_q <= accept;
            if (accept) begin
                tag_q  <= bus.MissTag;
                vtag_q <= bus.VictimTag;
                set_q  <= bus.MissSet;
                way_q  <= bus.VictimWay;
                line_q <= bus.VictimLine;
            end else if (state == FETCH && beat_en) begin
                line_q[int'(beat)*WORDLEN +: WORDLEN] <= bus.BusRData;
            end
        end
    end

endmodule
